// File: rtl/datapath_seq_pkg.sv
// rtl/datapath_seq_pkg.sv - shared states, opcodes and opcode classes for the sequencer
package datapath_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    localparam logic [4:0] OP_BR   = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_LD   = 5'd2;
    localparam logic [4:0] OP_ST   = 5'd3;
    localparam logic [4:0] OP_JSR  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_MOV  = 5'd6;
    localparam logic [4:0] OP_JSRR = 5'd7;
    localparam logic [4:0] OP_JMP  = 5'd12;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JUMP,
        CL_LINK,
        CL_ILLEGAL
    } op_class_e;

    // Classes whose instruction boundary is the exit from EXEC.
    function automatic logic ends_in_exec(input op_class_e c);
        return (c == CL_BRANCH) || (c == CL_JUMP) || (c == CL_ILLEGAL);
    endfunction

endpackage

// File: rtl/datapath_seq_if.sv
// rtl/datapath_seq_if.sv - control/handshake bundle between sequencer and datapath
interface datapath_seq_if;
    logic       lock;
    logic [4:0] opcode;
    logic       br_taken;
    logic       mem_ready;
    logic       fetch_en;
    logic       decode_en;
    logic       exec_en;
    logic       mem_req;
    logic       mem_we;
    logic       ld_reg;
    logic       pc_load;
    logic       illegal_op;
    logic       mem_err;

    modport master (
        input  lock, opcode, br_taken, mem_ready,
        output fetch_en, decode_en, exec_en, mem_req, mem_we,
               ld_reg, pc_load, illegal_op, mem_err
    );

    modport slave (
        output lock, opcode, br_taken, mem_ready,
        input  fetch_en, decode_en, exec_en, mem_req, mem_we,
               ld_reg, pc_load, illegal_op, mem_err
    );
endinterface

// File: rtl/datapath_seq_op_classify.sv
// rtl/datapath_seq_op_classify.sv - combinational opcode to opcode-class decode
module op_classify
    import datapath_pkg::*;
(
    input  logic [4:0] i_opcode,
    output op_class_e  o_class
);

    always_comb begin
        o_class = CL_ILLEGAL;
        case (i_opcode)
            OP_ADD, OP_AND, OP_MOV: o_class = CL_ALU;
            OP_LD:                  o_class = CL_LOAD;
            OP_ST:                  o_class = CL_STORE;
            OP_BR:                  o_class = CL_BRANCH;
            OP_JMP:                 o_class = CL_JUMP;
            OP_JSR, OP_JSRR:        o_class = CL_LINK;
            default:                o_class = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/datapath_seq.sv
// rtl/datapath_seq.sv - multi-cycle fetch/decode/exec/mem/wb sequencer
// Optional performance counters are built when DATAPATH_SEQ_PERF_EN is defined.
module datapath_seq
    import datapath_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    datapath_seq_if.master   bus,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int                WAIT_W   = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_e            r_state;
    state_e            w_next;
    state_e            w_park;
    op_class_e         r_class;
    op_class_e         w_class;
    logic [WAIT_W-1:0] r_wait;
    logic              w_timeout;

    op_classify u_classify (
        .i_opcode (bus.opcode),
        .o_class  (w_class)
    );

    // At an instruction boundary a low lock parks the sequencer instead of fetching.
    assign w_park    = bus.lock ? ST_FETCH : ST_IDLE;
    assign w_timeout = (r_wait == WAIT_MAX);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (bus.lock) w_next = ST_FETCH;
            ST_FETCH:  w_next = ST_DECODE;
            ST_DECODE: w_next = ST_EXEC;
            ST_EXEC: begin
                if (ends_in_exec(r_class))                         w_next = w_park;
                else if (r_class == CL_LOAD || r_class == CL_STORE) w_next = ST_MEM;
                else                                               w_next = ST_WB;
            end
            ST_MEM: begin
                if (bus.mem_ready)  w_next = (r_class == CL_STORE) ? w_park : ST_WB;
                else if (w_timeout) w_next = w_park;
            end
            ST_WB:     w_next = w_park;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_class <= CL_ALU;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) r_class <= w_class;
            if (r_state != ST_MEM)                      r_wait <= '0;
            else if (!bus.mem_ready && !w_timeout)      r_wait <= r_wait + 1'b1;
        end
    end

    assign bus.fetch_en   = (r_state == ST_FETCH);
    assign bus.decode_en  = (r_state == ST_DECODE);
    assign bus.exec_en    = (r_state == ST_EXEC);
    assign bus.mem_req    = (r_state == ST_MEM);
    assign bus.mem_we     = (r_state == ST_MEM) && (r_class == CL_STORE);
    assign bus.ld_reg     = (r_state == ST_WB);
    assign bus.pc_load    = (r_state == ST_EXEC) &&
                            ((r_class == CL_JUMP) || (r_class == CL_LINK) ||
                             ((r_class == CL_BRANCH) && bus.br_taken));
    assign bus.illegal_op = (r_state == ST_EXEC) && (r_class == CL_ILLEGAL);
    assign bus.mem_err    = (r_state == ST_MEM) && !bus.mem_ready && w_timeout;
    assign state          = r_state;

`ifdef DATAPATH_SEQ_PERF_EN
    logic             w_retire;
    logic [CNT_W-1:0] r_retired;
    logic [CNT_W-1:0] r_stall;

    assign w_retire = (r_state == ST_WB) ||
                      ((r_state == ST_EXEC) && ends_in_exec(r_class)) ||
                      ((r_state == ST_MEM) && bus.mem_ready && (r_class == CL_STORE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
            r_stall   <= '0;
        end else begin
            if (w_retire) r_retired <= r_retired + 1'b1;
            if ((r_state == ST_MEM) && !bus.mem_ready) r_stall <= r_stall + 1'b1;
        end
    end

    assign retired      = r_retired;
    assign stall_cycles = r_stall;
`else
    assign retired      = '0;
    assign stall_cycles = '0;
`endif

endmodule
